// File: rtl/slice_sequencer.sv
// Bit-serial (sliced) RV32I instruction sequencer: steps a datapath through
// NUM_SLICES execution cycles, optional memory handshake and a write-back pass.
module slice_sequencer #(
  parameter  int XLEN       = 32,
  parameter  int SLICE_W    = 16,
  localparam int NUM_SLICES = XLEN / SLICE_W,
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  output logic [IDX_W-1:0] slice_idx_o,
  output logic             slice_first_o,
  output logic             slice_last_o,
  output logic             slice_dir_o,
  output logic             alu_en_o,
  output logic             rf_write_o,
  output logic             cmp_req_o,
  output logic             illegal_o,
  output logic             done_o
);

  if ((XLEN % SLICE_W) != 0 || SLICE_W > XLEN) begin : g_param_check
    $error("slice_sequencer: SLICE_W must divide XLEN and not exceed it");
  end

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_SLICES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE,
    S_ILL
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [6:0]       r_opcode;
  logic [2:0]       r_funct3;
  logic [6:0]       r_funct7;

  logic       w_accept;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_is_op, w_is_opimm, w_is_branch, w_is_load, w_is_store;
  logic       w_legal, w_is_slt, w_is_shr, w_dir, w_rf_exec;
  logic       w_cnt_last, w_in_pass;

  // Decode looks at the live inputs on the accept edge so the registered
  // strobes of the first EXEC cycle already reflect the new instruction.
  assign w_accept = inst_valid_i && (r_state == S_IDLE);
  assign w_op     = w_accept ? opcode_i : r_opcode;
  assign w_f3     = w_accept ? funct3_i : r_funct3;
  assign w_f7     = w_accept ? funct7_i : r_funct7;

  assign w_is_op     = (w_op == OPC_OP);
  assign w_is_opimm  = (w_op == OPC_OP_IMM);
  assign w_is_branch = (w_op == OPC_BRANCH);
  assign w_is_load   = (w_op == OPC_LOAD);
  assign w_is_store  = (w_op == OPC_STORE);
  assign w_legal     = w_is_op || w_is_opimm || w_is_branch || w_is_load || w_is_store ||
                       (w_op == OPC_LUI) || (w_op == OPC_AUIPC) ||
                       (w_op == OPC_JAL) || (w_op == OPC_JALR);
  assign w_is_slt    = (w_is_op || w_is_opimm) && (w_f3 == 3'b010 || w_f3 == 3'b011);
  assign w_is_shr    = (w_is_op || w_is_opimm) && (w_f3 == 3'b101) &&
                       ((w_f7 & 7'b1011111) == 7'b0000000);
  assign w_dir       = w_is_slt || w_is_shr || (w_is_branch && w_f3[2]);
  assign w_rf_exec   = ((w_op == OPC_LUI) || (w_op == OPC_AUIPC) || (w_op == OPC_JAL) ||
                        (w_op == OPC_JALR) || w_is_op || w_is_opimm) && !w_is_slt;

  assign w_cnt_last = (r_cnt == LAST_CNT);

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; a missing
    // branch would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_legal ? S_EXEC : S_ILL;
      S_EXEC: begin
        if (!w_cnt_last)                   w_cnt_nxt   = r_cnt + IDX_W'(1);
        else if (w_is_load || w_is_store)  w_state_nxt = S_MEM;
        else if (w_is_slt)                 w_state_nxt = S_WB;
        else                               w_state_nxt = S_DONE;
      end
      S_MEM:  if (dmem_ack_i) w_state_nxt = w_is_load ? S_WB : S_DONE;
      S_WB: begin
        if (!w_cnt_last) w_cnt_nxt   = r_cnt + IDX_W'(1);
        else             w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ILL:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_in_pass = (w_state_nxt == S_EXEC) || (w_state_nxt == S_WB);
  assign w_idx_nxt = ((w_state_nxt == S_EXEC) && w_dir) ? (LAST_CNT - w_cnt_nxt) : w_cnt_nxt;

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_opcode      <= '0;
      r_funct3      <= '0;
      r_funct7      <= '0;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      slice_idx_o   <= '0;
      slice_first_o <= 1'b0;
      slice_last_o  <= 1'b0;
      slice_dir_o   <= 1'b0;
      alu_en_o      <= 1'b0;
      rf_write_o    <= 1'b0;
      cmp_req_o     <= 1'b0;
      illegal_o     <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_opcode <= opcode_i;
        r_funct3 <= funct3_i;
        r_funct7 <= funct7_i;
      end
      dmem_req_o    <= (w_state_nxt == S_MEM);
      dmem_we_o     <= (w_state_nxt == S_MEM) && w_is_store;
      slice_idx_o   <= w_idx_nxt;
      slice_first_o <= w_in_pass && (w_cnt_nxt == '0);
      slice_last_o  <= w_in_pass && (w_cnt_nxt == LAST_CNT);
      slice_dir_o   <= w_dir && (w_state_nxt inside {S_EXEC, S_MEM, S_WB, S_DONE});
      alu_en_o      <= (w_state_nxt == S_EXEC);
      rf_write_o    <= ((w_state_nxt == S_EXEC) && w_rf_exec) || (w_state_nxt == S_WB);
      cmp_req_o     <= (w_state_nxt == S_EXEC) && w_is_branch && (w_cnt_nxt == LAST_CNT);
      illegal_o     <= (w_state_nxt == S_ILL);
      done_o        <= (w_state_nxt == S_DONE);
    end
  end

  // Ready follows the state register but drops immediately while reset is held.
  assign inst_ready_o = (r_state == S_IDLE) && !rst;

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer: a 2-slice instance (default widths) and
// a 4-slice instance (SLICE_W=8) share reset, instruction fields and ack.
module tb_slice_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid2, valid4;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ack;

  logic       r2_ready, r2_req, r2_we, r2_first, r2_last, r2_dir, r2_alu, r2_rf, r2_cmp, r2_ill, r2_done;
  logic [0:0] r2_idx;
  logic       r4_ready, r4_req, r4_we, r4_first, r4_last, r4_dir, r4_alu, r4_rf, r4_cmp, r4_ill, r4_done;
  logic [1:0] r4_idx;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  slice_sequencer dut2 (
    .clk(clk), .rst(rst), .inst_valid_i(valid2), .inst_ready_o(r2_ready),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .dmem_req_o(r2_req), .dmem_we_o(r2_we), .dmem_ack_i(ack),
    .slice_idx_o(r2_idx), .slice_first_o(r2_first), .slice_last_o(r2_last),
    .slice_dir_o(r2_dir), .alu_en_o(r2_alu), .rf_write_o(r2_rf), .cmp_req_o(r2_cmp),
    .illegal_o(r2_ill), .done_o(r2_done)
  );

  slice_sequencer #(.XLEN(32), .SLICE_W(8)) dut4 (
    .clk(clk), .rst(rst), .inst_valid_i(valid4), .inst_ready_o(r4_ready),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .dmem_req_o(r4_req), .dmem_we_o(r4_we), .dmem_ack_i(ack),
    .slice_idx_o(r4_idx), .slice_first_o(r4_first), .slice_last_o(r4_last),
    .slice_dir_o(r4_dir), .alu_en_o(r4_alu), .rf_write_o(r4_rf), .cmp_req_o(r4_cmp),
    .illegal_o(r4_ill), .done_o(r4_done)
  );

  // Packed layout: ready | alu rf cmp | req we | ill done | dir first last | idx
  logic [11:0] obs2;
  logic [12:0] obs4;
  assign obs2 = {r2_ready, r2_alu, r2_rf, r2_cmp, r2_req, r2_we, r2_ill, r2_done,
                 r2_dir, r2_first, r2_last, r2_idx};
  assign obs4 = {r4_ready, r4_alu, r4_rf, r4_cmp, r4_req, r4_we, r4_ill, r4_done,
                 r4_dir, r4_first, r4_last, r4_idx};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [11:0] exp);
    check(tag, {4'b0, obs2}, {4'b0, exp});
  endtask

  task automatic chk4(input string tag, input logic [12:0] exp);
    check(tag, {3'b0, obs4}, {3'b0, exp});
  endtask

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    valid2 = 1'b1;
  endtask

  initial begin
    rst = 1'b1; valid2 = 1'b0; valid4 = 1'b0; ack = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;
    tick(); tick();
    chk2("reset_n2", 12'b0);
    chk4("reset_n4", 13'b0);
    rst = 1'b0;
    #1;
    chk2("rst_release_n2", 12'b1_000_00_00_000_0);
    chk4("rst_release_n4", 13'b1_000_00_00_000_00);

    // SRA on the 4-slice instance: MSB-first, rf write every EXEC cycle
    opcode = 7'b0110011; funct3 = 3'b101; funct7 = 7'b0100000; valid4 = 1'b1;
    tick(); valid4 = 1'b0;
    chk4("sra_idx3", 13'b0_110_00_00_110_11);
    chk2("n2_idle_during_sra", 12'b1_000_00_00_000_0);
    tick(); chk4("sra_idx2", 13'b0_110_00_00_100_10);
    tick(); chk4("sra_idx1", 13'b0_110_00_00_100_01);
    tick(); chk4("sra_idx0", 13'b0_110_00_00_101_00);
    tick(); chk4("sra_done", 13'b0_000_00_01_100_00);
    tick(); chk4("sra_idle", 13'b1_000_00_00_000_00);

    // ADD; valid held high with an illegal opcode during EXEC must be ignored
    issue(7'b0110011, 3'b000, 7'b0000000);
    tick(); opcode = 7'b1111111;
    chk2("add_s0", 12'b0_110_00_00_010_0);
    tick(); chk2("add_s1", 12'b0_110_00_00_001_1);
    tick(); valid2 = 1'b0;
    chk2("add_done", 12'b0_000_00_01_000_0);
    tick(); chk2("add_idle", 12'b1_000_00_00_000_0);

    // SLTU: MSB-first EXEC without rf write, then LSB-first WB
    issue(7'b0110011, 3'b011, 7'b0000000);
    tick(); valid2 = 1'b0;
    chk2("sltu_e_idx1", 12'b0_100_00_00_110_1);
    tick(); chk2("sltu_e_idx0", 12'b0_100_00_00_101_0);
    tick(); chk2("sltu_wb_idx0", 12'b0_010_00_00_110_0);
    tick(); chk2("sltu_wb_idx1", 12'b0_010_00_00_101_1);
    tick(); chk2("sltu_done", 12'b0_000_00_01_100_0);
    tick(); chk2("sltu_idle", 12'b1_000_00_00_000_0);

    // BLT: compare request only on the final slice
    issue(7'b1100011, 3'b100, 7'b0000000);
    tick(); valid2 = 1'b0;
    chk2("blt_idx1", 12'b0_100_00_00_110_1);
    tick(); chk2("blt_idx0_cmp", 12'b0_101_00_00_101_0);
    tick(); chk2("blt_done", 12'b0_000_00_01_100_0);
    tick(); chk2("blt_idle", 12'b1_000_00_00_000_0);

    // SW: stray ack during EXEC ignored, ack in the fourth MEM cycle
    issue(7'b0100011, 3'b010, 7'b0000000);
    tick(); valid2 = 1'b0; ack = 1'b1;
    chk2("sw_e0", 12'b0_100_00_00_010_0);
    tick(); ack = 1'b0;
    chk2("sw_e1", 12'b0_100_00_00_001_1);
    tick(); chk2("sw_mem1", 12'b0_000_11_00_000_0);
    tick(); chk2("sw_mem2", 12'b0_000_11_00_000_0);
    tick(); chk2("sw_mem3", 12'b0_000_11_00_000_0);
    tick(); ack = 1'b1;
    chk2("sw_mem4", 12'b0_000_11_00_000_0);
    tick(); ack = 1'b0;
    chk2("sw_done", 12'b0_000_00_01_000_0);
    tick(); chk2("sw_idle", 12'b1_000_00_00_000_0);

    // LW: ack in the first MEM cycle, then a WB pass
    issue(7'b0000011, 3'b010, 7'b0000000);
    tick(); valid2 = 1'b0;
    chk2("lw_e0", 12'b0_100_00_00_010_0);
    tick(); chk2("lw_e1", 12'b0_100_00_00_001_1);
    tick(); ack = 1'b1;
    chk2("lw_mem", 12'b0_000_10_00_000_0);
    tick(); ack = 1'b0;
    chk2("lw_wb0", 12'b0_010_00_00_010_0);
    tick(); chk2("lw_wb1", 12'b0_010_00_00_001_1);
    tick(); chk2("lw_done", 12'b0_000_00_01_000_0);
    tick(); chk2("lw_idle", 12'b1_000_00_00_000_0);

    // Illegal opcode
    issue(7'b1111111, 3'b000, 7'b0000000);
    tick(); valid2 = 1'b0;
    chk2("ill_pulse", 12'b0_000_00_10_000_0);
    tick(); chk2("ill_idle", 12'b1_000_00_00_000_0);

    // Reset while a LW waits for ack in MEM
    issue(7'b0000011, 3'b010, 7'b0000000);
    tick(); valid2 = 1'b0;
    tick();
    tick(); chk2("rst_mem_pending", 12'b0_000_10_00_000_0);
    rst = 1'b1;
    tick(); chk2("rst_abort_n2", 12'b0);
    chk4("rst_abort_n4", 13'b0);
    rst = 1'b0;
    #1;
    chk2("rst_abort_ready", 12'b1_000_00_00_000_0);
    tick(); chk2("rst_abort_no_done1", 12'b1_000_00_00_000_0);
    tick(); chk2("rst_abort_no_done2", 12'b1_000_00_00_000_0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/slice_sequencer.md
SLICE_SEQUENCER -- requirements
Module: slice_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have parameter SLICE_W, default 16, bits processed per execution cycle; NUM_SLICES = XLEN/SLICE_W (derived).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port inst_valid_i  in  1  instruction fields valid.
REQ-006 SHALL have port inst_ready_o  out  1  sequencer can accept an instruction.
REQ-007 SHALL have ports opcode_i in 7, funct3_i in 3, funct7_i in 7  RV32I instruction fields.
REQ-008 SHALL have ports dmem_req_o out 1, dmem_we_o out 1, dmem_ack_i in 1  data-memory handshake.
REQ-009 SHALL have port slice_idx_o  out  max(1,$clog2(NUM_SLICES))  current slice index.
REQ-010 SHALL have ports slice_first_o out 1, slice_last_o out 1  first/last slice of current pass.
REQ-011 SHALL have port slice_dir_o  out  1  0 = LSB-first, 1 = MSB-first.
REQ-012 SHALL have ports alu_en_o, rf_write_o, cmp_req_o  out  1 each  per-slice datapath strobes.
REQ-013 SHALL have ports illegal_o out 1, done_o out 1  single-cycle completion pulses.

Function
REQ-014 SHALL fail elaboration if XLEN mod SLICE_W != 0 or SLICE_W > XLEN.
REQ-015 SHALL implement states IDLE, EXEC, MEM, WB, DONE, ILL.
REQ-016 SHALL assert inst_ready_o only in IDLE; accept and register opcode/funct3/funct7 when inst_valid_i && inst_ready_o.
REQ-017 SHALL on accept go to EXEC for legal opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP), else to ILL.
REQ-018 SHALL in ILL pulse illegal_o for one cycle, assert no other strobe, then return to IDLE.
REQ-019 SHALL set slice_dir_o=1 for BLT/BGE/BLTU/BGEU, SLT/SLTU (reg and imm), SRL/SRA/SRLI/SRAI; 0 otherwise; held constant from accept to DONE.
REQ-020 SHALL remain in EXEC exactly NUM_SLICES cycles; slice_idx_o counts 0..N-1 when LSB-first, N-1..0 when MSB-first.
REQ-021 SHALL assert slice_first_o on the first and slice_last_o on the final cycle of every EXEC or WB pass; both high together when NUM_SLICES=1.
REQ-022 SHALL assert alu_en_o every EXEC cycle for all legal opcodes.
REQ-023 SHALL assert rf_write_o every EXEC cycle for LUI, AUIPC, JAL, JALR, OP, OP_IMM except SLT/SLTU forms.
REQ-024 SHALL for SLT/SLTU forms follow EXEC with WB: NUM_SLICES cycles, LSB-first index order, rf_write_o high each cycle, alu_en_o low.
REQ-025 SHALL assert cmp_req_o only on the last EXEC slice of BRANCH; BRANCH never asserts rf_write_o.
REQ-026 SHALL after EXEC of LOAD/STORE enter MEM: dmem_req_o high, dmem_we_o = 1 for STORE, held until dmem_ack_i sampled high (ack in first MEM cycle allowed).
REQ-027 SHALL after MEM ack for LOAD enter WB (as REQ-024); for STORE go directly to DONE.
REQ-028 SHALL pulse done_o for one cycle in DONE, then return to IDLE.
REQ-029 SHALL give non-memory, non-WB latency: accept at cycle T, EXEC T+1..T+N, done_o at T+N+1, inst_ready_o at T+N+2.
REQ-030 SHALL ignore dmem_ack_i outside MEM and inst_valid_i outside IDLE.
REQ-031 SHALL deassert all strobes (alu_en_o, rf_write_o, cmp_req_o, dmem_req_o) outside their stated states.

Reset
REQ-032 SHALL while rst is high drive every output 0 (including inst_ready_o) and state IDLE, counter 0, registered fields 0.
REQ-033 SHALL on rst mid-operation abort at the next edge, dropping dmem_req_o without ack and suppressing done_o.
REQ-034 SHALL assert inst_ready_o in the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover: N=2, ADD (0110011, f3=000) accepted at T -> alu_en_o+rf_write_o at T+1,T+2, idx 0,1, done_o at T+3.
REQ-036 SHALL cover: SLICE_W=8 (N=4), SRA (f3=101, f7=0100000) -> slice_dir_o=1, idx 3,2,1,0, first at idx 3, last at idx 0, rf_write_o high each EXEC cycle.
REQ-037 SHALL cover: N=2, SLTU -> EXEC 2 cycles rf_write_o low, WB 2 cycles idx 0,1 rf_write_o high, done_o 5 cycles after accept.
REQ-038 SHALL cover: SW with dmem_ack_i delayed 3 cycles -> dmem_req_o+dmem_we_o high 4 cycles, done_o next cycle; LW with ack in first MEM cycle -> WB pass follows.
REQ-039 SHALL cover: opcode 1111111 -> illegal_o one cycle after accept, no strobes, inst_ready_o two cycles after accept.
REQ-040 SHALL cover: rst asserted during MEM with ack pending -> next cycle all outputs 0, done_o never pulses, inst_ready_o high first cycle after rst release.
